// File: rtl/ag32gbd_buffer_reader.sv
// ag32gbd_buffer_reader
// Frame-buffer read client for the dual-buffer BRAM controller's port-B path.
// Fetches one frame of packed 2bpp bytes, one request at a time, and unpacks each byte
// MSB-first into four 2-bit pixels on a valid/ready stream.
//
// Ports:
//   sys_clock, resetn           clock, asynchronous active-low reset
//   Start                       one-cycle pulse, read a frame from offset 0 (ignored while Busy)
//   Busy, Done                  frame in progress / one-cycle pulse after the final handshake
//   RequestReadBuffer           one-cycle read request to the controller
//   BufferReadOffset            byte offset of the current request
//   BufferReadOutput            read data, valid READ_LATENCY edges after the request edge
//   PixelData/Valid/Ready       pixel stream
//   PixelFirst, PixelLast       qualify first and last pixel of the frame
//
// Build option: define AG32GBD_BUFFER_READER_PREFETCH_EN to add a one-byte holding register
// so the next byte is fetched while the current one is shifted out.
module ag32gbd_buffer_reader #(
  parameter int unsigned BYTES_PER_FRAME = 256,
  parameter int unsigned READ_LATENCY    = 2
) (
  input  logic       sys_clock,
  input  logic       resetn,
  input  logic       Start,
  output logic       Busy,
  output logic       Done,
  output logic       RequestReadBuffer,
  output logic [9:0] BufferReadOffset,
  input  logic [7:0] BufferReadOutput,
  output logic [1:0] PixelData,
  output logic       PixelValid,
  input  logic       PixelReady,
  output logic       PixelFirst,
  output logic       PixelLast
);

`ifdef AG32GBD_BUFFER_READER_PREFETCH_EN
  localparam bit PrefetchEn = 1'b1;
`else
  localparam bit PrefetchEn = 1'b0;
`endif

  localparam int unsigned CntW     = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CntW-1:0] WaitLast = CntW'(READ_LATENCY - 1);
  localparam logic [9:0]      LastIdx  = 10'(BYTES_PER_FRAME - 1);

  // StShift: the fetch side is parked until the shifter (or holding register) frees up.
  typedef enum logic [1:0] {StIdle, StReq, StWait, StShift} state_e;

  state_e          state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [9:0]      fetch_idx_q, fetch_idx_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]      sh_q, sh_d;
  logic            sh_valid_q, sh_valid_d;
  logic [1:0]      pix_cnt_q, pix_cnt_d;
  logic [9:0]      sh_idx_q, sh_idx_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_valid_q, hold_valid_d;

  logic hs;
  logic sh_drain;
  logic sh_free;

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    fetch_idx_d  = fetch_idx_q;
    wait_cnt_d   = wait_cnt_q;
    sh_d         = sh_q;
    sh_valid_d   = sh_valid_q;
    pix_cnt_d    = pix_cnt_q;
    sh_idx_d     = sh_idx_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;

    hs       = sh_valid_q && PixelReady;
    sh_drain = hs && (pix_cnt_q == 2'd3);
    // The shifter can accept a byte on the same edge as its p3 handshake.
    sh_free  = !sh_valid_q || sh_drain;

    if (hs) begin
      sh_d      = {sh_q[5:0], 2'b00};
      pix_cnt_d = pix_cnt_q + 2'd1;
      if (sh_drain) begin
        sh_valid_d = 1'b0;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          fetch_idx_d = '0;
          busy_d      = 1'b1;
          state_d     = StReq;
        end
      end
      StReq: begin
        wait_cnt_d = '0;
        state_d    = StWait;
      end
      StWait: begin
        if (wait_cnt_q == WaitLast) begin
          if (sh_free) begin
            sh_d       = BufferReadOutput;
            sh_valid_d = 1'b1;
            pix_cnt_d  = 2'd0;
            sh_idx_d   = fetch_idx_q;
            if (PrefetchEn && (fetch_idx_q != LastIdx)) begin
              fetch_idx_d = fetch_idx_q + 10'd1;
              state_d     = StReq;
            end else begin
              state_d = StShift;
            end
          end else begin
            // Only reachable with prefetch: shifter still busy, park the byte.
            hold_d       = BufferReadOutput;
            hold_valid_d = 1'b1;
            state_d      = StShift;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
      end
      StShift: begin
        if (sh_drain) begin
          if (sh_idx_q == LastIdx) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end else if (PrefetchEn) begin
            if (hold_valid_q) begin
              sh_d         = hold_q;
              sh_valid_d   = 1'b1;
              pix_cnt_d    = 2'd0;
              sh_idx_d     = fetch_idx_q;
              hold_valid_d = 1'b0;
              if (fetch_idx_q != LastIdx) begin
                fetch_idx_d = fetch_idx_q + 10'd1;
                state_d     = StReq;
              end
            end
          end else begin
            fetch_idx_d = fetch_idx_q + 10'd1;
            state_d     = StReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fetch_idx_q  <= '0;
      wait_cnt_q   <= '0;
      sh_q         <= '0;
      sh_valid_q   <= 1'b0;
      pix_cnt_q    <= '0;
      sh_idx_q     <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fetch_idx_q  <= fetch_idx_d;
      wait_cnt_q   <= wait_cnt_d;
      sh_q         <= sh_d;
      sh_valid_q   <= sh_valid_d;
      pix_cnt_q    <= pix_cnt_d;
      sh_idx_q     <= sh_idx_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign Busy              = busy_q;
  assign Done              = done_q;
  assign RequestReadBuffer = (state_q == StReq);
  assign BufferReadOffset  = fetch_idx_q;
  assign PixelValid        = sh_valid_q;
  assign PixelData         = sh_q[7:6];
  assign PixelFirst        = sh_valid_q && (sh_idx_q == 10'd0) && (pix_cnt_q == 2'd0);
  assign PixelLast         = sh_valid_q && (sh_idx_q == LastIdx) && (pix_cnt_q == 2'd3);

endmodule

// File: tb/tb_ag32gbd_buffer_reader.sv
module tb_ag32gbd_buffer_reader;

  logic       sys_clock = 1'b0;
  logic       resetn;
  logic       Start;
  logic       Busy, Done, RequestReadBuffer;
  logic [9:0] BufferReadOffset;
  logic [7:0] BufferReadOutput;
  logic [1:0] PixelData;
  logic       PixelValid, PixelReady, PixelFirst, PixelLast;

  logic       s_start, s_busy, s_done, s_req, s_valid, s_ready, s_first, s_last;
  logic [9:0] s_off;
  logic [7:0] s_rdata;
  logic [1:0] s_data;

  always #5 sys_clock = ~sys_clock;

  ag32gbd_buffer_reader #(.BYTES_PER_FRAME(256), .READ_LATENCY(2)) u_dut (
    .sys_clock(sys_clock), .resetn(resetn), .Start(Start), .Busy(Busy), .Done(Done),
    .RequestReadBuffer(RequestReadBuffer), .BufferReadOffset(BufferReadOffset),
    .BufferReadOutput(BufferReadOutput), .PixelData(PixelData), .PixelValid(PixelValid),
    .PixelReady(PixelReady), .PixelFirst(PixelFirst), .PixelLast(PixelLast)
  );

  ag32gbd_buffer_reader #(.BYTES_PER_FRAME(1), .READ_LATENCY(2)) u_small (
    .sys_clock(sys_clock), .resetn(resetn), .Start(s_start), .Busy(s_busy), .Done(s_done),
    .RequestReadBuffer(s_req), .BufferReadOffset(s_off), .BufferReadOutput(s_rdata),
    .PixelData(s_data), .PixelValid(s_valid), .PixelReady(s_ready), .PixelFirst(s_first),
    .PixelLast(s_last)
  );

  // Controller model: data appears exactly two edges after the request edge, junk otherwise.
  logic [7:0] mem [256];
  logic       v1, sv1;
  logic [7:0] d1, sd1;
  always @(posedge sys_clock) begin
    v1               <= RequestReadBuffer;
    d1               <= mem[BufferReadOffset[7:0]];
    BufferReadOutput <= v1 ? d1 : 8'hEE;
    sv1              <= s_req;
    sd1              <= (s_off == 10'd0) ? 8'h1B : 8'h77;
    s_rdata          <= sv1 ? sd1 : 8'hEE;
  end

  int unsigned total = 0;
  int unsigned bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Monitor (sole writer of everything below).
  int unsigned cyc = 0;
  always @(posedge sys_clock) cyc <= cyc + 1;

  int unsigned offs[$];
  logic [3:0]  pix[$];
  int unsigned done_cnt = 0, done_cyc = 0, last_cyc = 0;
  int unsigned low_cnt = 0, stall_cnt = 0, stall_err = 0;
  bit          in_frame = 0, prev_stall = 0;
  logic [3:0]  prev_pix = '0;

  always @(negedge sys_clock) begin
    if (resetn) begin
      if (RequestReadBuffer) offs.push_back(32'(BufferReadOffset));
      if (Done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (prev_stall && (!PixelValid || ({PixelFirst, PixelLast, PixelData} != prev_pix)))
        stall_err++;
      if (PixelValid && PixelReady) begin
        pix.push_back({PixelFirst, PixelLast, PixelData});
        if (PixelFirst) in_frame = 1;
        if (PixelLast) begin
          in_frame = 0;
          last_cyc = cyc;
        end
      end else if (in_frame && !PixelValid) begin
        low_cnt++;
      end
      if (PixelValid && !PixelReady) stall_cnt++;
      prev_stall = PixelValid && !PixelReady;
      prev_pix   = {PixelFirst, PixelLast, PixelData};
    end else begin
      prev_stall = 0;
      in_frame   = 0;
    end
  end

  function automatic logic [3:0] exp_pix(input int j, input int nbytes);
    logic [7:0] b;
    int         sh;
    b  = mem[j / 4];
    sh = 6 - 2 * (j % 4);
    return {j == 0, j == 4 * nbytes - 1, b[sh +: 2]};
  endfunction

  task automatic pulse_start();
    @(posedge sys_clock); #1 Start = 1'b1;
    @(posedge sys_clock); #1 Start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned dbase, input int unsigned limit, input bit rnd,
                           input int unsigned start_at);
    int unsigned n = 0;
    while (done_cnt == dbase && n < limit) begin
      @(posedge sys_clock); #1;
      n++;
      if (rnd) PixelReady = 1'($urandom_range(0, 1));
      Start = (n == start_at);
    end
    Start = 1'b0;
    PixelReady = 1'b1;
    check("done_timeout", longint'(done_cnt != dbase), 1);
    repeat (20) @(posedge sys_clock);
    #1;
  endtask

  task automatic check_frame(input string tag, input int pbase, input int obase,
                             input int unsigned dbase);
    int perr = 0, oerr = 0;
    check({tag, "_pix_count"}, pix.size() - pbase, 1024);
    for (int j = 0; j < 1024 && pbase + j < pix.size(); j++)
      if (pix[pbase + j] !== exp_pix(j, 256)) perr++;
    check({tag, "_pix_errs"}, perr, 0);
    check({tag, "_req_count"}, offs.size() - obase, 256);
    for (int i = 0; i < 256 && obase + i < offs.size(); i++)
      if (offs[obase + i] != i) oerr++;
    check({tag, "_offset_errs"}, oerr, 0);
    check({tag, "_done_count"}, done_cnt - dbase, 1);
    check({tag, "_busy_after"}, Busy, 0);
  endtask

  typedef struct {
    int         idx;
    logic [3:0] exp;  // {first, last, data}
  } vec_t;

  vec_t vecs[12];
  logic [3:0] small_exp[4];
  logic [3:0] small_got[8];

  initial begin
    int pbase, obase, lbase;
    int unsigned dbase, sbase, n, scount, sreq, sdone;

    vecs[0]  = '{0,    4'b1000};
    vecs[1]  = '{3,    4'b0000};
    vecs[2]  = '{7,    4'b0001};
    vecs[3]  = '{11,   4'b0010};
    vecs[4]  = '{14,   4'b0000};
    vecs[5]  = '{15,   4'b0011};
    vecs[6]  = '{109,  4'b0001};
    vecs[7]  = '{110,  4'b0010};
    vecs[8]  = '{512,  4'b0010};
    vecs[9]  = '{700,  4'b0010};
    vecs[10] = '{1020, 4'b0011};
    vecs[11] = '{1023, 4'b0111};
    small_exp[0] = 4'b1000;
    small_exp[1] = 4'b0001;
    small_exp[2] = 4'b0010;
    small_exp[3] = 4'b0111;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    resetn = 1'b0;
    Start = 1'b0;
    PixelReady = 1'b1;
    s_start = 1'b0;
    s_ready = 1'b1;
    repeat (2) @(posedge sys_clock);
    #1;
    check("reset_outputs", {Busy, Done, RequestReadBuffer, BufferReadOffset, PixelValid,
                            PixelData, PixelFirst, PixelLast}, 0);
    resetn = 1'b1;

    // Single frame, PixelReady held high: latency, stream content, throughput.
    pbase = pix.size(); obase = offs.size(); dbase = done_cnt; lbase = int'(low_cnt);
    pulse_start();
    check("busy_after_start", Busy, 1);
    check("req_after_start", {RequestReadBuffer, BufferReadOffset}, 11'h400);
    @(posedge sys_clock); #1;
    check("req_one_cycle", RequestReadBuffer, 0);
    @(posedge sys_clock); #1;
    check("valid_early", PixelValid, 0);
    @(posedge sys_clock); #1;
    check("valid_latency", {PixelValid, PixelFirst, PixelData}, 4'b1100);
    wait_done(dbase, 5000, 1'b0, 0);
    check_frame("frame1", pbase, obase, dbase);
    for (int v = 0; v < 12; v++)
      check($sformatf("vec_pix%0d", vecs[v].idx), pix[pbase + vecs[v].idx], vecs[v].exp);
`ifdef AG32GBD_BUFFER_READER_PREFETCH_EN
    check("valid_gap_cycles", int'(low_cnt) - lbase, 0);
`else
    check("valid_gap_cycles", int'(low_cnt) - lbase, 255 * 3);
`endif
    check("done_after_last", done_cyc - last_cyc, 1);

    // Backpressure with a Start pulse mid-frame that must be ignored.
    mem[0] = 8'hB4;
    pbase = pix.size(); obase = offs.size(); dbase = done_cnt; sbase = stall_cnt;
    pulse_start();
    wait_done(dbase, 8000, 1'b1, 400);
    check_frame("bp", pbase, obase, dbase);
    check("bp_first_byte", {pix[pbase][1:0], pix[pbase + 1][1:0], pix[pbase + 2][1:0],
                            pix[pbase + 3][1:0]}, 8'b10_11_01_00);
    check("bp_stalls_seen", longint'(stall_cnt > sbase), 1);
    check("bp_stall_stable", stall_err, 0);
    mem[0] = 8'h00;

    // Reset mid-frame at byte 100, then a clean restart.
    obase = offs.size(); dbase = done_cnt;
    pulse_start();
    n = 0;
    while (offs.size() - obase < 101 && n < 3000) begin
      @(posedge sys_clock); #1;
      n++;
    end
    check("reach_byte100", longint'(offs.size() - obase >= 101), 1);
    #2 resetn = 1'b0;
    #1;
    check("reset_mid_outputs", {Busy, Done, RequestReadBuffer, BufferReadOffset, PixelValid,
                                PixelData, PixelFirst, PixelLast}, 0);
    repeat (3) @(posedge sys_clock);
    #1 resetn = 1'b1;
    repeat (5) @(posedge sys_clock);
    #1;
    check("reset_no_done", done_cnt - dbase, 0);
    pbase = pix.size(); obase = offs.size(); dbase = done_cnt;
    pulse_start();
    wait_done(dbase, 5000, 1'b0, 0);
    check_frame("restart", pbase, obase, dbase);

    // One-byte frame on the second instance.
    scount = 0; sreq = 0; sdone = 0;
    @(posedge sys_clock); #1 s_start = 1'b1;
    @(posedge sys_clock); #1 s_start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge sys_clock);
      if (s_valid && scount < 8) begin
        small_got[scount] = {s_first, s_last, s_data};
        scount++;
      end
      if (s_req) sreq++;
      if (s_done) sdone++;
    end
    check("small_pix_count", scount, 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("small_pix%0d", k), small_got[k], small_exp[k]);
    check("small_req_count", sreq, 1);
    check("small_done_count", sdone, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
